// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial W link: FSM state encoding and default sizing.
// Used by the transmit-side stuffer and the receive-side destuffer.
package serial_link_pkg;

    // Default word width and forbidden run length
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_RUN = 4;

    // Transmit / receive FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_STUF  = 2'd2;

endpackage

// File: rtl/serial_stuff_tx_run_tracker.sv
// Run tracker: follows the length of the current run of equal bits on the line
// and flags when the bit just presented completes MAX_RUN-1 equal bits, i.e. a
// complement bit must follow. A stuff bit always starts a fresh run of length 1.
module run_tracker #(
    parameter int MAX_RUN = serial_link_pkg::DEF_MAX_RUN
) (
    input  logic CLK,
    input  logic RST,
    input  logic BIT_EN,     // a data bit is on the line this cycle
    input  logic BIT_VAL,    // value of that data bit
    input  logic STUFF_EN,   // a stuff bit is on the line this cycle
    input  logic CLEAR,      // line goes idle: forget the run
    output logic STUFF_REQ   // data bit this cycle completes MAX_RUN-1 equal bits
);

    localparam int RUN_W = $clog2(MAX_RUN);

    logic [RUN_W-1:0] run_cnt_r;
    logic             last_bit_r;
    logic [RUN_W-1:0] run_upd_s;

    // Run length including the bit presented this cycle
    always_comb begin
        run_upd_s = RUN_W'(1);
        if ((BIT_VAL == last_bit_r) && (run_cnt_r != RUN_W'(0))) begin
            run_upd_s = run_cnt_r + RUN_W'(1);
        end else begin
            run_upd_s = RUN_W'(1);
        end
    end

    assign STUFF_REQ = BIT_EN && (run_upd_s == RUN_W'(MAX_RUN - 1));

    // Run history register; idle clear only drops the count, the last level is kept
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_cnt_r  <= RUN_W'(0);
            last_bit_r <= 1'b1;
        end else if (CLEAR) begin
            run_cnt_r  <= RUN_W'(0);
        end else if (STUFF_EN) begin
            run_cnt_r  <= RUN_W'(1);
            last_bit_r <= ~last_bit_r;
        end else if (BIT_EN) begin
            run_cnt_r  <= run_upd_s;
            last_bit_r <= BIT_VAL;
        end else begin
            run_cnt_r  <= run_cnt_r;
            last_bit_r <= last_bit_r;
        end
    end

endmodule

// File: rtl/serial_stuff_tx.sv
// Serial W line transmitter: accepts parallel words over valid/ready, shifts
// them out MSB-first one bit per clock and inserts a complement stuff bit after
// every MAX_RUN-1 equal bits so the far-end run detector never fires.
// All line outputs are registered; the register holds what is on W this cycle.
module serial_stuff_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              W,
    output logic              W_EN,
    output logic              STUFF,
    output logic              BUSY
);

    localparam int IDX_W = $clog2(DATA_W);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [DATA_W-1:0] sreg_r;
    logic [DATA_W-1:0] sreg_nxt_s;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [IDX_W-1:0]  bit_idx_nxt_s;

    logic w_r;
    logic w_en_r;
    logic stuff_r;
    logic busy_r;
    logic w_nxt_s;
    logic w_en_nxt_s;
    logic stuff_nxt_s;
    logic busy_nxt_s;

    logic cur_bit_s;
    logic stuff_req_s;
    logic din_ready_s;
    logic accept_s;
    logic clear_s;

    // Data bit currently on the line (meaningful in SHIFT)
    assign cur_bit_s = sreg_r[bit_idx_r];

    run_tracker #(
        .MAX_RUN (MAX_RUN)
    ) u_run_tracker (
        .CLK       (CLK),
        .RST       (RST),
        .BIT_EN    (state_r == ST_SHIFT),
        .BIT_VAL   (cur_bit_s),
        .STUFF_EN  (state_r == ST_STUF),
        .CLEAR     (clear_s),
        .STUFF_REQ (stuff_req_s)
    );

    // Ready when the line will be free for a new word's MSB next cycle
    always_comb begin
        din_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  din_ready_s = 1'b1;
            ST_SHIFT: din_ready_s = (bit_idx_r == IDX_W'(0)) && !stuff_req_s;
            ST_STUF:  din_ready_s = (bit_idx_r == IDX_W'(0));
            default:  din_ready_s = 1'b0;
        endcase
    end

    assign accept_s  = DIN_VALID && din_ready_s;
    assign DIN_READY = din_ready_s;
    assign clear_s   = (state_nxt_s == ST_IDLE);

    // Next-state logic: bit index only advances when leaving a data bit without a pending stuff
    always_comb begin
        state_nxt_s   = state_r;
        sreg_nxt_s    = sreg_r;
        bit_idx_nxt_s = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = ST_SHIFT;
                    sreg_nxt_s    = DIN;
                    bit_idx_nxt_s = IDX_W'(DATA_W - 1);
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (stuff_req_s) begin
                    state_nxt_s   = ST_STUF;
                end else if (bit_idx_r != IDX_W'(0)) begin
                    bit_idx_nxt_s = bit_idx_r - IDX_W'(1);
                end else if (accept_s) begin
                    sreg_nxt_s    = DIN;
                    bit_idx_nxt_s = IDX_W'(DATA_W - 1);
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_STUF: begin
                if (bit_idx_r != IDX_W'(0)) begin
                    state_nxt_s   = ST_SHIFT;
                    bit_idx_nxt_s = bit_idx_r - IDX_W'(1);
                end else if (accept_s) begin
                    state_nxt_s   = ST_SHIFT;
                    sreg_nxt_s    = DIN;
                    bit_idx_nxt_s = IDX_W'(DATA_W - 1);
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // Line outputs for the coming cycle; STUF is only entered from SHIFT, so its level is ~current bit
    always_comb begin
        w_nxt_s     = 1'b1;
        w_en_nxt_s  = 1'b0;
        stuff_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                w_nxt_s     = 1'b1;
                w_en_nxt_s  = 1'b0;
                stuff_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
            ST_SHIFT: begin
                w_nxt_s     = sreg_nxt_s[bit_idx_nxt_s];
                w_en_nxt_s  = 1'b1;
                stuff_nxt_s = 1'b0;
                busy_nxt_s  = 1'b1;
            end
            ST_STUF: begin
                w_nxt_s     = ~cur_bit_s;
                w_en_nxt_s  = 1'b1;
                stuff_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            default: begin
                w_nxt_s     = 1'b1;
                w_en_nxt_s  = 1'b0;
                stuff_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, shift register and registered line outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            sreg_r    <= DATA_W'(0);
            bit_idx_r <= IDX_W'(0);
            w_r       <= 1'b1;
            w_en_r    <= 1'b0;
            stuff_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sreg_r    <= sreg_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            w_r       <= w_nxt_s;
            w_en_r    <= w_en_nxt_s;
            stuff_r   <= stuff_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign W     = w_r;
    assign W_EN  = w_en_r;
    assign STUFF = stuff_r;
    assign BUSY  = busy_r;

endmodule

// File: tb/tb_serial_stuff_tx.sv
// Directed and randomized bench for serial_stuff_tx (DATA_W=8, MAX_RUN=4).
module tb_serial_stuff_tx;

    localparam int MAX_RUN = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       W;
    logic       W_EN;
    logic       STUFF;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    // random-phase reference state
    logic [7:0] sent_q[$];
    int         m_run = 0;
    logic       m_last = 1'b1;
    logic       m_exp_st = 1'b0;
    int         m_nb = 0;
    logic [7:0] m_word = 8'h00;
    int         raw_run = 0;
    logic       raw_last = 1'b1;

    serial_stuff_tx #(
        .DATA_W  (8),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .W         (W),
        .W_EN      (W_EN),
        .STUFF     (STUFF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_w"}, W, 1'b1);
        chk({tag, "_wen"}, W_EN, 1'b0);
        chk({tag, "_stuff"}, STUFF, 1'b0);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_rdy"}, DIN_READY, 1'b1);
    endtask

    // Send one or two words (second streamed back-to-back) and check n line cycles, first cycle at bit n-1
    task automatic run_seq(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input int nwords, input int n,
                           input logic [31:0] ew, input logic [31:0] es, input logic [31:0] er);
        int  left;
        logic acc;
        DIN = w0;
        DIN_VALID = 1'b1;
        step();
        left = nwords - 1;
        if (left > 0) begin
            DIN = w1;
        end else begin
            DIN_VALID = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            chk({tag, "_w"}, W, ew[n-1-i]);
            chk({tag, "_wen"}, W_EN, 1'b1);
            chk({tag, "_stuff"}, STUFF, es[n-1-i]);
            chk({tag, "_busy"}, BUSY, 1'b1);
            chk({tag, "_rdy"}, DIN_READY, er[n-1-i]);
            acc = DIN_VALID && DIN_READY;
            step();
            if (acc) begin
                left--;
                DIN_VALID = 1'b0;
            end
        end
        chk({tag, "_left"}, left, 32'd0);
        chk_idle({tag, "_end"});
    endtask

    // Reference destuffer for one sampled cycle
    task automatic mon_cycle();
        logic nl;
        logic [7:0] expw;
        if (W_EN) begin
            raw_run  = (W == raw_last && raw_run != 0) ? raw_run + 1 : 1;
            raw_last = W;
            chk("rnd_line_run", raw_run < MAX_RUN, 1'b1);
            if (m_exp_st) begin
                nl = ~m_last;
                chk("rnd_stuff_flag", STUFF, 1'b1);
                chk("rnd_stuff_val", W, nl);
                m_last   = W;
                m_run    = 1;
                m_exp_st = 1'b0;
            end else begin
                chk("rnd_data_flag", STUFF, 1'b0);
                m_run  = (W == m_last && m_run != 0) ? m_run + 1 : 1;
                m_last = W;
                m_word = {m_word[6:0], W};
                m_nb++;
                if (m_nb == 8) begin
                    m_nb = 0;
                    if (sent_q.size() == 0) begin
                        chk("rnd_extra_word", m_word, 32'hFFFF_FFFF);
                    end else begin
                        expw = sent_q.pop_front();
                        chk("rnd_word", m_word, expw);
                    end
                end
                if (m_run == MAX_RUN - 1) begin
                    m_exp_st = 1'b1;
                end
            end
        end else begin
            chk("rnd_idle_gap", {m_exp_st, (m_nb != 0)}, 2'b00);
            chk("rnd_idle_line", {W, STUFF, BUSY}, 3'b100);
            m_run   = 0;
            raw_run = 0;
        end
    endtask

    initial begin
        logic acc;
        // reset
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        chk_idle("reset");

        // single word, no stuffing
        run_seq("a5", 8'hA5, 8'h00, 1, 8, 32'b10100101, 32'b0, 32'b00000001);
        // all zeros: two stuffs
        run_seq("00", 8'h00, 8'h00, 1, 10, 32'b0001000100, 32'b0001000100, 32'b0000000001);
        // trailing stuff after the last data bit
        run_seq("07", 8'h07, 8'h00, 1, 10, 32'b0001001110, 32'b0001000001, 32'b0000000001);
        // back-to-back words, run history carried across the boundary
        run_seq("b2b", 8'h03, 8'hC0, 2, 21,
                32'b000100011101100010001, 32'b000100010010000010001, 32'b000000000010000000001);

        // reset in cycle 3 of a word aborts it
        DIN = 8'h00;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("abort");
        step();
        chk_idle("abort_hold");
        run_seq("ff", 8'hFF, 8'h00, 1, 10, 32'b1110111011, 32'b0001000100, 32'b0000000001);

        // reset and valid together: word is dropped
        DIN = 8'h5A;
        DIN_VALID = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        DIN_VALID = 1'b0;
        chk_idle("rst_vs_valid");
        step();
        chk_idle("rst_vs_valid2");

        // random traffic against the reference destuffer
        DIN_VALID = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            mon_cycle();
            acc = DIN_VALID && DIN_READY;
            if (acc) begin
                sent_q.push_back(DIN);
            end
            step();
            if (acc || !DIN_VALID) begin
                DIN_VALID = ($urandom_range(0, 3) != 0);
                DIN = 8'($urandom);
            end
        end
        DIN_VALID = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mon_cycle();
            step();
        end
        chk("rnd_drained", sent_q.size(), 32'd0);
        chk("rnd_partial", m_nb, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
